// File: rtl/avl_mem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// avl_mem_responder
//
// Avalon-MM memory responder. This is the slave end of the avl_* port that
// cache_shared drives. Words live in an internal array. The block accepts
// single and burst reads and writes, and returns read bursts after a fixed
// latency. It stands in for the DRAM controller in cache-level simulation and
// acts as on-chip backing store in small builds.
//
// Ports
//   clk             : single clock, all logic on posedge
//   reset           : asynchronous, active-low reset
//   avl_ready       : command / write beat can be accepted this cycle
//   avl_addr        : word address of first beat (only low MEM_AW bits used)
//   avl_size        : burst length in beats (1 .. 2^SIZE_W-1)
//   avl_wdata       : write data beat
//   avl_be          : byte enables for the write beat
//   avl_write_req   : write command / beat valid
//   avl_read_req    : read command valid
//   avl_burstbegin  : first beat of a burst
//   avl_rdata       : read data beat
//   avl_rdata_valid : avl_rdata valid this cycle
//   proto_err       : sticky protocol-violation flag
//
// Optional feature: define AVL_RESP_BACKPRESSURE_EN to add a 16-bit LFSR
// (seed 16'hACE1). The LFSR stalls avl_ready in IDLE whenever lfsr[1:0]==0.
// -----------------------------------------------------------------------------
module avl_mem_responder #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 24,
  parameter int SIZE_W    = 3,
  parameter int MEM_AW    = 10,
  parameter int RD_LAT    = 4,
  parameter int RDQ_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                avl_ready,
  input  logic [ADDR_W-1:0]   avl_addr,
  input  logic [SIZE_W-1:0]   avl_size,
  input  logic [DATA_W-1:0]   avl_wdata,
  input  logic [DATA_W/8-1:0] avl_be,
  input  logic                avl_write_req,
  input  logic                avl_read_req,
  input  logic                avl_burstbegin,
  output logic [DATA_W-1:0]   avl_rdata,
  output logic                avl_rdata_valid,
  output logic                proto_err
);

  localparam int BE_W = DATA_W / 8;
  localparam int QAW  = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;
  localparam int WT_W = $clog2(RD_LAT);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WR_BURST = 1'b1;

  logic [0:0]        state, nxt_state;
  logic              ready_en;
  logic              bp_stall;
  logic [MEM_AW-1:0] wr_base, nxt_base;
  logic [SIZE_W-1:0] wr_size, nxt_size;
  logic [SIZE_W-1:0] wr_cnt, nxt_cnt;

  logic [DATA_W-1:0] mem [2**MEM_AW];

  // Each queued read also carries its countdown. An entry may start
  // streaming only once its countdown reaches zero. This keeps the latency
  // from acceptance fixed whenever the engine is idle, and it lets a queued
  // entry follow the previous burst with no bubble.
  logic [MEM_AW-1:0] q_addr [RDQ_DEPTH];
  logic [SIZE_W-1:0] q_size [RDQ_DEPTH];
  logic [WT_W-1:0]   q_wait [RDQ_DEPTH];
  logic [QAW-1:0]    q_wr_ptr, q_rd_ptr;
  logic [QAW:0]      q_count;
  logic              q_full, q_empty;
  logic [SIZE_W-1:0] rd_beat;

  logic              accept, q_push, q_pop, beat_fire, beat_last, err;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_waddr;
  logic [MEM_AW-1:0] rd_index;

  logic unused_addr_hi;
  assign unused_addr_hi = ^avl_addr[ADDR_W-1:MEM_AW];

  function automatic logic [QAW-1:0] ptr_inc(input logic [QAW-1:0] p);
    return (p == QAW'(RDQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef AVL_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign bp_stall = (lfsr[1:0] == 2'b00);
`else
  assign bp_stall = 1'b0;
`endif

  assign q_full  = (q_count == (QAW+1)'(RDQ_DEPTH));
  assign q_empty = (q_count == '0);

  // Continuation beats of a write burst are never stalled. Only new commands
  // in IDLE wait for a free queue slot or for the optional stall.
  assign avl_ready = ready_en & ((state == ST_WR_BURST) | (~q_full & ~bp_stall));

  // Command decode and the write-burst state machine.
  always_comb begin
    accept    = avl_ready & (avl_write_req | avl_read_req);
    err       = 1'b0;
    q_push    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = avl_addr[MEM_AW-1:0];
    nxt_state = state;
    nxt_base  = wr_base;
    nxt_size  = wr_size;
    nxt_cnt   = wr_cnt;
    if (accept) begin
      if (avl_write_req && avl_read_req) begin
        err = 1'b1;
      end else if (avl_read_req) begin
        if (state == ST_WR_BURST || avl_size == '0) err = 1'b1;
        else                                         q_push = 1'b1;
      end else if (avl_burstbegin) begin
        // A burstbegin while a burst is still open abandons the old burst.
        if (state == ST_WR_BURST) err = 1'b1;
        if (avl_size == '0) begin
          err       = 1'b1;
          nxt_state = ST_IDLE;
        end else begin
          mem_we    = 1'b1;
          nxt_base  = avl_addr[MEM_AW-1:0];
          nxt_size  = avl_size;
          nxt_cnt   = SIZE_W'(1);
          nxt_state = (avl_size == SIZE_W'(1)) ? ST_IDLE : ST_WR_BURST;
        end
      end else if (state == ST_WR_BURST) begin
        mem_we    = 1'b1;
        mem_waddr = wr_base + MEM_AW'(wr_cnt);
        nxt_cnt   = wr_cnt + 1'b1;
        if (wr_cnt == wr_size - 1'b1) nxt_state = ST_IDLE;
      end else begin
        err = 1'b1;
      end
    end
  end

  // Read engine. The head entry streams one beat per cycle once its
  // countdown has expired.
  always_comb begin
    beat_fire = ~q_empty & (q_wait[q_rd_ptr] == '0);
    beat_last = (rd_beat == q_size[q_rd_ptr] - 1'b1);
    q_pop     = beat_fire & beat_last;
    rd_index  = q_addr[q_rd_ptr] + MEM_AW'(rd_beat);
  end

  // Array and queue payload are not reset. Only the pointers that give them
  // meaning are reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (avl_be[b]) mem[mem_waddr][b*8 +: 8] <= avl_wdata[b*8 +: 8];
      end
    end
    for (int i = 0; i < RDQ_DEPTH; i++) begin
      if (q_push && (q_wr_ptr == QAW'(i))) begin
        q_addr[i] <= avl_addr[MEM_AW-1:0];
        q_size[i] <= avl_size;
        q_wait[i] <= WT_W'(RD_LAT - 1);
      end else if (q_wait[i] != '0) begin
        q_wait[i] <= q_wait[i] - 1'b1;
      end
    end
  end

  // Control state, queue pointers and registered read outputs.
  // The array is read at beat output time, so any write accepted at an
  // earlier edge is visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      ready_en        <= 1'b0;
      wr_base         <= '0;
      wr_size         <= '0;
      wr_cnt          <= '0;
      proto_err       <= 1'b0;
      q_wr_ptr        <= '0;
      q_rd_ptr        <= '0;
      q_count         <= '0;
      rd_beat         <= '0;
      avl_rdata_valid <= 1'b0;
      avl_rdata       <= '0;
    end else begin
      ready_en <= 1'b1;
      state    <= nxt_state;
      wr_base  <= nxt_base;
      wr_size  <= nxt_size;
      wr_cnt   <= nxt_cnt;
      if (err) proto_err <= 1'b1;
      if (q_push) q_wr_ptr <= ptr_inc(q_wr_ptr);
      if (q_pop)  q_rd_ptr <= ptr_inc(q_rd_ptr);
      q_count <= q_count + (QAW+1)'(q_push) - (QAW+1)'(q_pop);
      avl_rdata_valid <= beat_fire;
      if (beat_fire) begin
        avl_rdata <= mem[rd_index];
        rd_beat   <= beat_last ? '0 : rd_beat + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avl_mem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_avl_mem_responder
//
// Randomized and directed stimulus for avl_mem_responder. The reference model
// is a plain word array. Read timing is modelled as "a burst starts at the
// later of acceptance+RD_LAT and the end of the previous burst". Each
// accepted read pushes its expected beats (data and output cycle) into a
// queue. A separate monitor pops that queue on every avl_rdata_valid and
// compares.
// -----------------------------------------------------------------------------
module tb_avl_mem_responder;

  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 24;
  localparam int SIZE_W    = 3;
  localparam int MEM_AW    = 10;
  localparam int RD_LAT    = 4;
  localparam int RDQ_DEPTH = 4;
  localparam int DEPTH     = 1 << MEM_AW;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                avl_ready;
  logic [ADDR_W-1:0]   avl_addr = '0;
  logic [SIZE_W-1:0]   avl_size = '0;
  logic [DATA_W-1:0]   avl_wdata = '0;
  logic [DATA_W/8-1:0] avl_be = '0;
  logic                avl_write_req = 1'b0;
  logic                avl_read_req = 1'b0;
  logic                avl_burstbegin = 1'b0;
  logic [DATA_W-1:0]   avl_rdata;
  logic                avl_rdata_valid;
  logic                proto_err;

  avl_mem_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W),
    .MEM_AW(MEM_AW), .RD_LAT(RD_LAT), .RDQ_DEPTH(RDQ_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .avl_ready(avl_ready), .avl_addr(avl_addr),
    .avl_size(avl_size), .avl_wdata(avl_wdata), .avl_be(avl_be),
    .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
    .avl_burstbegin(avl_burstbegin), .avl_rdata(avl_rdata),
    .avl_rdata_valid(avl_rdata_valid), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] model_mem [DEPTH];
  int                eng_free = 0;
  int                test_cnt = 0;
  int                fail_cnt = 0;
  logic [DATA_W-1:0] wbuf [8];
  logic [7:0]        bebuf [8];

  task automatic check_output(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] req);
    test_cnt++;
    if (act !== req) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic report_timeout(input string name);
    test_cnt++;
    fail_cnt++;
    $display("[TB] FAIL %s: timed out waiting, got no event, expected event (t=%0t)", name, $time);
  endtask

  // Monitor: every beat the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (reset === 1'b1 && avl_rdata_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_beat", avl_rdata_valid, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("rdata", avl_rdata, e.data);
        check_output("beat_cycle", 64'(cycle), 64'(e.cyc));
      end
    end
  end

  task automatic model_write(input int idx, input logic [DATA_W-1:0] d, input logic [7:0] be);
    for (int b = 0; b < 8; b++) begin
      if (be[b]) model_mem[idx % DEPTH][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic push_expect(input int a, input int n, input int acc);
    int start;
    exp_t e;
    start = (acc + RD_LAT > eng_free) ? acc + RD_LAT : eng_free;
    for (int i = 0; i < n; i++) begin
      e.data = model_mem[(a + i) % DEPTH];
      e.cyc  = start + i;
      exp_q.push_back(e);
    end
    eng_free = start + n;
  endtask

  // Called at a negedge. Holds the request until avl_ready is seen and
  // returns at the negedge after the accepting posedge, or acc=-1 on timeout.
  task automatic apply_stimulus(input logic wr, input logic rd, input logic bb,
                                input logic [ADDR_W-1:0] addr, input logic [SIZE_W-1:0] size,
                                input logic [DATA_W-1:0] data, input logic [7:0] be,
                                output int acc);
    int waited;
    waited = 0;
    avl_write_req  = wr;
    avl_read_req   = rd;
    avl_burstbegin = bb;
    avl_addr       = addr;
    avl_size       = size;
    avl_wdata      = data;
    avl_be         = be;
    while (avl_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (avl_ready !== 1'b1) begin
      report_timeout("handshake");
      acc = -1;
    end else begin
      acc = cycle + 1;
      @(negedge clk);
    end
    avl_write_req  = 1'b0;
    avl_read_req   = 1'b0;
    avl_burstbegin = 1'b0;
  endtask

  task automatic write_burst(input int a, input int n);
    int acc;
    logic [ADDR_W-1:0] fa;
    fa = {14'($urandom), a[MEM_AW-1:0]};
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b1, 1'b0, (i == 0), fa, SIZE_W'(n), wbuf[i], bebuf[i], acc);
      if (acc >= 0) model_write(a + i, wbuf[i], bebuf[i]);
    end
  endtask

  task automatic read_cmd(input int a, input int n, output int acc);
    logic [ADDR_W-1:0] fa;
    fa = {14'($urandom), a[MEM_AW-1:0]};
    apply_stimulus(1'b0, 1'b1, 1'b1, fa, SIZE_W'(n), '0, '0, acc);
    if (acc >= 0) push_expect(a, n, acc);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      report_timeout("drain");
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    avl_write_req  = 1'b0;
    avl_read_req   = 1'b0;
    avl_burstbegin = 1'b0;
    exp_q.delete();
    eng_free = 0;
  endtask

  task automatic release_reset();
    repeat (3) @(negedge clk);
    check_output("rst_ready", avl_ready, 1'b0);
    check_output("rst_valid", avl_rdata_valid, 1'b0);
    check_output("rst_rdata", avl_rdata, '0);
    check_output("rst_proto_err", proto_err, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_output("ready_after_reset", avl_ready, 1'b1);
  endtask

  initial begin
    int acc, acc_r, a, n, k;
    int accs[5];
    logic [DATA_W-1:0] old;

    assert_reset();
    release_reset();

    // Preload every word so later reads always have defined contents.
    for (int base = 0; base < DEPTH; base += 7) begin
      n = (DEPTH - base < 7) ? DEPTH - base : 7;
      for (int i = 0; i < n; i++) begin
        wbuf[i]  = {$urandom, $urandom};
        bebuf[i] = 8'hFF;
      end
      write_burst(base, n);
    end

    // Single write then read at 97.
    wbuf[0] = 64'd8; bebuf[0] = 8'hFF;
    write_burst(97, 1);
    read_cmd(97, 1, acc);
    wait_drain();

    // Four-beat burst at 300.
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 64'(i + 1); bebuf[i] = 8'hFF;
    end
    write_burst(300, 4);
    read_cmd(300, 4, acc);
    wait_drain();

    // Partial byte enables over word 0.
    old = model_mem[0];
    wbuf[0] = '1; bebuf[0] = 8'h0F;
    write_burst(0, 1);
    check_output("be_model", model_mem[0], {old[63:32], 32'hFFFF_FFFF});
    read_cmd(0, 1, acc);
    wait_drain();

    // Burst crossing the top of the array wraps to index 0.
    wbuf[0] = 64'hAAAA_0001; wbuf[1] = 64'hBBBB_0002; bebuf[0] = 8'hFF; bebuf[1] = 8'hFF;
    write_burst(DEPTH - 1, 2);
    read_cmd(DEPTH - 1, 2, acc);
    read_cmd(0, 1, acc);
    wait_drain();

    // A write accepted after a read command but before its beat is seen.
    apply_stimulus(1'b0, 1'b1, 1'b1, 24'd640, 3'd1, '0, '0, acc_r);
    wbuf[0] = 64'h0123_4567_89AB_CDEF; bebuf[0] = 8'hFF;
    write_burst(640, 1);
    if (acc_r >= 0) push_expect(640, 1, acc_r);
    wait_drain();

    // RDQ_DEPTH+1 back-to-back reads: the last waits for the first to drain.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b1, ADDR_W'(100 + 2*i), 3'd2, '0, '0, accs[i]);
      if (accs[i] >= 0) push_expect(100 + 2*i, 2, accs[i]);
    end
    check_output("q_b2b_accept", 64'(accs[3]), 64'(accs[0] + 3));
    check_output("q_full_stall", 64'(accs[4]), 64'(accs[0] + RD_LAT + 2));
    wait_drain();

    // Randomized traffic: write batch, then a read batch, then drain.
    for (int it = 0; it < 25; it++) begin
      k = $urandom_range(1, 3);
      for (int w = 0; w < k; w++) begin
        a = $urandom_range(0, DEPTH - 1);
        n = $urandom_range(1, 7);
        for (int i = 0; i < n; i++) begin
          wbuf[i]  = {$urandom, $urandom};
          bebuf[i] = 8'($urandom);
        end
        write_burst(a, n);
      end
      k = $urandom_range(1, 6);
      for (int r = 0; r < k; r++) begin
        read_cmd($urandom_range(0, DEPTH - 1), $urandom_range(1, 7), acc);
      end
      wait_drain();
    end
    check_output("no_err_clean", proto_err, 1'b0);

    // size==0 write is dropped.
    old = model_mem[50];
    apply_stimulus(1'b1, 1'b0, 1'b1, 24'd50, 3'd0, 64'hDEAD, 8'hFF, acc);
    check_output("err_size0", proto_err, 1'b1);
    read_cmd(50, 1, acc);
    wait_drain();
    assert_reset();
    release_reset();

    // Read and write together is dropped.
    apply_stimulus(1'b1, 1'b1, 1'b1, 24'd60, 3'd1, 64'hBEEF, 8'hFF, acc);
    check_output("err_rd_wr", proto_err, 1'b1);
    read_cmd(60, 1, acc);
    wait_drain();
    assert_reset();
    release_reset();

    // Write without burstbegin in IDLE is dropped.
    apply_stimulus(1'b1, 1'b0, 1'b0, 24'd70, 3'd1, 64'hF00D, 8'hFF, acc);
    check_output("err_no_bb", proto_err, 1'b1);
    read_cmd(70, 1, acc);
    wait_drain();
    assert_reset();
    release_reset();

    // Read during a write burst is ignored; the burst still completes.
    apply_stimulus(1'b1, 1'b0, 1'b1, 24'd80, 3'd3, 64'h11, 8'hFF, acc);
    if (acc >= 0) model_write(80, 64'h11, 8'hFF);
    apply_stimulus(1'b0, 1'b1, 1'b0, 24'd80, 3'd1, '0, '0, acc);
    check_output("err_rd_in_burst", proto_err, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 24'd80, 3'd3, 64'h22, 8'hFF, acc);
    if (acc >= 0) model_write(81, 64'h22, 8'hFF);
    apply_stimulus(1'b1, 1'b0, 1'b0, 24'd80, 3'd3, 64'h33, 8'hFF, acc);
    if (acc >= 0) model_write(82, 64'h33, 8'hFF);
    read_cmd(80, 3, acc);
    wait_drain();
    assert_reset();
    release_reset();

    // Reset in the middle of a read burst.
    read_cmd(500, 7, acc);
    k = 0;
    while (avl_rdata_valid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (avl_rdata_valid !== 1'b1) report_timeout("rst_burst_start");
    @(negedge clk);
    #2;
    assert_reset();
    #1;
    check_output("rst_async_valid", avl_rdata_valid, 1'b0);
    check_output("rst_async_rdata", avl_rdata, '0);
    release_reset();
    repeat (20) @(negedge clk);
    read_cmd(500, 7, acc);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
